aig_vector_harness: RTL and testbench
=====================================

Name: aig_vector_harness

Overview:
- Sequential stimulus/response harness that sits directly upstream and downstream of a generated combinational benchmark netlist, such as a 21-input / 10-output CCGRCG-class AIG.
- Drives pseudo-random 21-bit input vectors (x0..x20) into the netlist and samples its 10 outputs (f1..f10) in the same cycle.
- Streams each {response, vector} record to a downstream dataset logger over valid/ready.
- Compacts all responses into a MISR signature for equivalence checks between netlist variants (e.g. RESYN2 vs. original).

Parameters:
- NI, 21, netlist input width (vector width; LFSR fixed at 21 bits in this revision).
- NO, 10, netlist output width.
- CW, 16, vector-count width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a run (sampled in IDLE or DONE only).
- num_vectors  in  CW  vectors per run; latched on accepted start.
- seed  in  NI  LFSR seed; latched on accepted start.
- vec_out  out  NI  registered vector to netlist inputs; bit i drives x_i.
- resp_in  in  NO  netlist outputs; bit j is f(j+1); combinational from vec_out.
- rec_valid  out  1  record available.
- rec_ready  in  1  logger accepts record.
- rec_data  out  NO+NI  {resp_in, vec_out}; combinational passthrough of resp_in.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- signature  out  16  MISR value; final when done=1.
- vec_count  out  CW  records transferred this run.

Behaviour:
- Reset: state=IDLE; vec_out=0; rec_valid=0; busy=0; done=0; signature=16'hFFFF; vec_count=0. Reset mid-run aborts immediately; no further records.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1:
  - Latch num_vectors; clear vec_count; signature=16'hFFFF.
  - vec_out = (seed==0) ? 21'h000001 : seed.
  - Next state is RUN, or DONE if num_vectors==0.
  - start in RUN is ignored.
- RUN: rec_valid=1.
  - Transfer = rec_valid & rec_ready.
  - On transfer, in the same clock edge:
    - MISR update with resp_in.
    - vec_count+1.
    - LFSR advance: vec_out <= {vec_out[19:0], vec_out[20]^vec_out[18]}.
  - If vec_count+1 == latched num_vectors, go to DONE; vec_out then holds the last-plus-one value (don't-care).
  - No transfer: vec_out, signature and vec_count hold. Backpressure of any length is lossless, and resp_in stays stable because vec_out is stable.
- MISR update: m' = {m[14:0],1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ {6'b0, resp_in}.
- Latency: first record is valid the cycle after the accepted start. With rec_ready held high, throughput is 1 record/cycle. done rises the cycle after the final transfer.
- rec_valid is 0 in IDLE and DONE; it never drops in RUN without a transfer (AXI-style stability).
- vec_count saturates naturally, since the run ends at num_vectors ≤ 2^CW−1.
- LFSR period is 2^21−1; runs longer than that repeat vectors (permitted).

Decomposition:
- Package aig_harness_pkg:
  - state enum {IDLE, RUN, DONE}.
  - LFSR_TAPS (bits 20, 18).
  - MISR_POLY = 16'h1021.
  - MISR_INIT = 16'hFFFF.
  - ZERO_SEED_SUB = 21'h000001.
- One sub-module, aig_misr16 (enable, data_in[NO-1:0], clear-to-init, sig out). The LFSR and FSM stay in the top module.

Test Plan:
- Reset then seed=21'h000001, num_vectors=3, rec_ready=1 → vec_out 0x000001, 0x000002, 0x000004 on consecutive records; done after 3 transfers; vec_count=3.
- seed=0, num_vectors=1, resp_in tied 10'h000 → first vec_out=0x000001; signature=16'hEFDF; done=1.
- num_vectors=0 start → next cycle done=1, rec_valid never asserted, signature=16'hFFFF.
- rec_ready toggled 1,0,0,1 with num_vectors=2 → rec_data stable across stall; exactly 2 transfers; vec_count=2; same signature as an unstalled run with identical resp_in.
- rst asserted mid-run after 1 transfer → next cycle IDLE, rec_valid=0, signature=16'hFFFF; start during RUN ignored (count unaffected).
- Netlist in loop with 1000 vectors: original and RESYN2 variants give equal signatures; single-gate fault injection gives unequal signatures.

Source files
------------

// File: rtl/aig_vector_harness_pkg.sv
// Shared types, constants and next-state helpers for the AIG vector harness.
//   state_e       : harness controller states
//   lfsr_next()   : 21-bit Fibonacci LFSR step (taps 20, 18)
//   misr_next()   : 16-bit MISR step with polynomial 0x1021
package aig_harness_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int          LFSR_W        = 21;
  localparam int          LFSR_TAP_HI   = 20;
  localparam int          LFSR_TAP_LO   = 18;
  localparam logic [15:0] MISR_POLY     = 16'h1021;
  localparam logic [15:0] MISR_INIT     = 16'hFFFF;
  // An all-zero seed would lock the LFSR, so it is replaced by this value.
  localparam logic [20:0] ZERO_SEED_SUB = 21'h000001;

  function automatic logic [20:0] lfsr_next(input logic [20:0] v);
    return {v[19:0], v[LFSR_TAP_HI] ^ v[LFSR_TAP_LO]};
  endfunction

  function automatic logic [15:0] misr_next(input logic [15:0] m, input logic [15:0] d);
    return {m[14:0], 1'b0} ^ (m[15] ? MISR_POLY : 16'h0000) ^ d;
  endfunction

endpackage

// File: rtl/aig_vector_harness_if.sv
// Record stream from the harness to the dataset logger.
//   rec_valid : record available (harness -> logger)
//   rec_ready : logger accepts record (logger -> harness)
//   rec_data  : {response, vector} record (harness -> logger)
interface aig_vector_harness_if #(
  parameter int W = 31
);
  logic         rec_valid;
  logic         rec_ready;
  logic [W-1:0] rec_data;

  modport master (output rec_valid, output rec_data, input rec_ready);
  modport slave  (input rec_valid, input rec_data, output rec_ready);
endinterface

// File: rtl/aig_vector_harness_misr.sv
// 16-bit multiple-input signature register compacting netlist responses.
//   clk, rst  : clock, synchronous active-high reset (signature -> 0xFFFF)
//   clear_i   : reload the initial value (takes priority over enable_i)
//   enable_i  : fold data_i into the signature this cycle
//   data_i    : NO-bit response, zero-extended to 16 bits
//   sig_o     : current signature
module aig_misr16
  import aig_harness_pkg::*;
#(
  parameter int NO = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          enable_i,
  input  logic [NO-1:0] data_i,
  output logic [15:0]   sig_o
);

  logic [15:0] sig_q;
  logic [15:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clear_i) begin
      sig_d = MISR_INIT;
    end else if (enable_i) begin
      sig_d = misr_next(sig_q, 16'(data_i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= MISR_INIT;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/aig_vector_harness.sv
// Stimulus/response harness around a combinational benchmark netlist.
// Drives LFSR vectors into the netlist, streams {response, vector} records
// over valid/ready and compacts every transferred response into a MISR.
//   clk, rst     : clock, synchronous active-high reset
//   start        : begin a run (honoured in IDLE or DONE only)
//   num_vectors  : records per run, latched on accepted start
//   seed         : LFSR seed, latched on accepted start
//   vec_out      : registered vector to netlist inputs
//   resp_in      : netlist outputs (combinational from vec_out)
//   rec          : record stream (master side)
//   busy / done  : in RUN / in DONE
//   signature    : MISR value, final when done=1
//   vec_count    : records transferred this run
module aig_vector_harness
  import aig_harness_pkg::*;
#(
  parameter int NI = LFSR_W,
  parameter int NO = 10,
  parameter int CW = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CW-1:0]         num_vectors,
  input  logic [NI-1:0]         seed,
  output logic [NI-1:0]         vec_out,
  input  logic [NO-1:0]         resp_in,
  aig_vector_harness_if.master  rec,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           signature,
  output logic [CW-1:0]         vec_count
);

  state_e        state_q, state_d;
  logic [NI-1:0] vec_q, vec_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] nvec_q, nvec_d;
  logic          misr_clr;
  logic          misr_en;
  logic          xfer;

  assign xfer = (state_q == RUN) && rec.rec_ready;

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    nvec_d   = nvec_q;
    misr_clr = 1'b0;
    misr_en  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          nvec_d   = num_vectors;
          cnt_d    = '0;
          misr_clr = 1'b1;
          vec_d    = (seed == '0) ? ZERO_SEED_SUB : seed;
          state_d  = (num_vectors == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // Without a transfer everything holds, so the netlist response
        // stays stable for however long the logger stalls.
        if (xfer) begin
          misr_en = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          vec_d   = lfsr_next(vec_q);
          if (cnt_d == nvec_q) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      nvec_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      nvec_q  <= nvec_d;
    end
  end

  aig_misr16 #(.NO(NO)) u_misr (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (misr_clr),
    .enable_i (misr_en),
    .data_i   (resp_in),
    .sig_o    (signature)
  );

  assign vec_out       = vec_q;
  assign vec_count     = cnt_q;
  assign busy          = (state_q == RUN);
  assign done          = (state_q == DONE);
  assign rec.rec_valid = (state_q == RUN);
  assign rec.rec_data  = {resp_in, vec_q};

endmodule

// File: tb/tb_aig_vector_harness.sv
module tb_aig_vector_harness;

  localparam int NI = 21;
  localparam int NO = 10;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] num_vectors = '0;
  logic [NI-1:0] seed = '0;
  logic [NI-1:0] vec_out;
  logic [NO-1:0] resp_in;
  logic          busy;
  logic          done;
  logic [15:0]   signature;
  logic [CW-1:0] vec_count;

  aig_vector_harness_if #(.W(NO+NI)) rec_if ();

  aig_vector_harness #(.NI(NI), .NO(NO), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_vectors (num_vectors),
    .seed        (seed),
    .vec_out     (vec_out),
    .resp_in     (resp_in),
    .rec         (rec_if),
    .busy        (busy),
    .done        (done),
    .signature   (signature),
    .vec_count   (vec_count)
  );

  always #5 clk = ~clk;

  int              variant = 0;
  bit              rand_ready = 1'b0;
  bit              ready_pat[$];
  logic [NO+NI-1:0] exp_q[$];
  int              valid_seen = 0;
  int              n_checks = 0;
  int              n_fail = 0;
  logic [15:0]     model_sig;

  // Behavioural netlist: 0 = original, 1 = RESYN2-style rewrite (equivalent),
  // 2 = single-gate fault on f4, other = outputs tied low.
  function automatic logic [NO-1:0] netlist(input logic [NI-1:0] x, input int v);
    logic [NO-1:0] f;
    for (int j = 0; j < NO; j++) begin
      case (v)
        0: f[j] = (x[j] & x[j+1]) ^ (x[j+10] | x[20-j]);
        1: f[j] = (~(x[j] & x[j+1])) ^ (~x[j+10] & ~x[20-j]);
        2: f[j] = (j == 3) ? ((x[j] | x[j+1]) ^ (x[j+10] | x[20-j]))
                           : ((x[j] & x[j+1]) ^ (x[j+10] | x[20-j]));
        default: f[j] = 1'b0;
      endcase
    end
    return f;
  endfunction

  assign resp_in = netlist(vec_out, variant);

  // Reference: vector sequence and signature from the arithmetic definitions.
  function automatic int unsigned ref_vnext(input int unsigned v);
    return ((v << 1) & 32'h1FFFFF) | (((v >> 20) ^ (v >> 18)) & 32'h1);
  endfunction

  function automatic int unsigned ref_misr(input int unsigned m, input int unsigned r);
    int unsigned t;
    t = (m << 1) & 32'hFFFF;
    if ((m & 32'h8000) != 0) t = t ^ 32'h1021;
    return t ^ r;
  endfunction

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load_model(input logic [NI-1:0] s, input int n, input int v);
    int unsigned vv, m, r;
    exp_q.delete();
    vv = (s == 0) ? 32'h1 : 32'(s);
    m  = 32'hFFFF;
    for (int i = 0; i < n; i++) begin
      r = 32'(netlist(NI'(vv), v));
      exp_q.push_back({NO'(r), NI'(vv)});
      m  = ref_misr(m, r);
      vv = ref_vnext(vv);
    end
    model_sig = 16'(m);
  endtask

  // logger ready driver
  initial begin
    rec_if.rec_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (ready_pat.size() > 0) rec_if.rec_ready = ready_pat.pop_front();
      else if (rand_ready) rec_if.rec_ready = 1'($urandom_range(0, 1));
      else rec_if.rec_ready = 1'b1;
    end
  end

  // monitor: scoreboard pop on transfer, stability during stalls
  initial begin
    bit               prev_stall = 1'b0;
    logic [NO+NI-1:0] prev_data = '0;
    logic [NO+NI-1:0] exp;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (rec_if.rec_valid) valid_seen++;
        if (prev_stall) begin
          check("stall_valid_held", rec_if.rec_valid, 1);
          check("stall_data_held", rec_if.rec_data, prev_data);
        end
        if (rec_if.rec_valid && rec_if.rec_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_record: got %0h, expected none", rec_if.rec_data);
          end else begin
            exp = exp_q.pop_front();
            $display("record %0h vec %06h resp %03h", vec_count, rec_if.rec_data[NI-1:0],
                     rec_if.rec_data[NO+NI-1:NI]);
            check("rec_data", rec_if.rec_data, exp);
          end
        end
        prev_stall = rec_if.rec_valid && !rec_if.rec_ready;
        prev_data  = rec_if.rec_data;
      end
    end
  end

  task automatic do_run(input logic [NI-1:0] s, input int n, input int v, output logic [15:0] sig_out);
    @(posedge clk);
    #1;
    variant = v;
    load_model(s, n, v);
    seed = s;
    num_vectors = CW'(n);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("first_valid", rec_if.rec_valid, (n > 0));
    check("busy_after_start", busy, (n > 0));
    for (int c = 0; c < n * 10 + 20 && !done; c++) @(negedge clk);
    check("done", done, 1);
    check("vec_count", vec_count, n);
    check("signature", signature, model_sig);
    check("valid_low_in_done", rec_if.rec_valid, 0);
    check("records_left", exp_q.size(), 0);
    $display("run seed %06h n %0d variant %0d sig %04h", s, n, v, signature);
    sig_out = signature;
  endtask

  logic [15:0]   sig, sig_ref, s0, s1, s2;
  logic [NI-1:0] s;

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_vec_out", vec_out, 0);
    check("rst_valid", rec_if.rec_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_signature", signature, 16'hFFFF);
    check("rst_vec_count", vec_count, 0);

    // seed 1, three vectors, no backpressure
    do_run(21'h000001, 3, 0, sig);

    // zero seed substitution, responses tied low
    do_run(21'h000000, 1, 3, sig);
    check("zero_resp_sig", sig, 16'hEFDF);

    // empty run
    valid_seen = 0;
    do_run(21'h001234, 0, 0, sig);
    check("n0_signature", sig, 16'hFFFF);
    repeat (3) @(negedge clk);
    check("n0_valid_seen", valid_seen, 0);

    // stalled run must match an unstalled one
    s = NI'($urandom);
    do_run(s, 2, 0, sig_ref);
    ready_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    do_run(s, 2, 0, sig);
    check("stall_sig_equal", sig, sig_ref);

    // start ignored in RUN, then reset mid-run
    s = NI'($urandom);
    ready_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    @(posedge clk);
    #1;
    variant = 0;
    load_model(s, 5, 0);
    seed = s;
    num_vectors = CW'(5);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1;
    seed = ~s;
    num_vectors = CW'(7);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("ignored_start_count", vec_count, 1);
    check("ignored_start_busy", busy, 1);
    check("ignored_start_vec", vec_out, exp_q[0][NI-1:0]);
    check("ignored_start_pending", exp_q.size(), 4);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    ready_pat.delete();
    @(negedge clk);
    check("midrst_valid", rec_if.rec_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_signature", signature, 16'hFFFF);
    check("midrst_vec_count", vec_count, 0);
    valid_seen = 0;
    repeat (5) @(negedge clk);
    check("midrst_no_records", valid_seen, 0);

    // randomized runs with random backpressure
    rand_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      do_run(NI'($urandom), int'($urandom_range(1, 40)), int'($urandom_range(0, 1)), sig);
    end
    rand_ready = 1'b0;

    // netlist variants over 1000 vectors
    s = NI'($urandom);
    do_run(s, 1000, 0, s0);
    do_run(s, 1000, 1, s1);
    do_run(s, 1000, 2, s2);
    check("resyn2_sig_equal", s1, s0);
    check("fault_sig_differs", (s2 != s0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
